// File: rtl/cpu_pipe_pkg.sv
// Shared types, constants and instruction-field helpers for the four-stage pipe tracker.
// Optional operand forwarding is selected with the FORWARD_EN macro.
package cpu_pipe_pkg;

  localparam int IW = 16;

  typedef logic [4:0]    opcode_t;
  typedef logic [IW-1:0] instr_t;
  typedef logic [2:0]    reg_idx_t;

  localparam opcode_t NOP_OPCODE  = 5'b00111;
  localparam opcode_t LOAD_OPCODE = 5'b00100;
  localparam instr_t  BUBBLE      = {{(IW-5){1'b0}}, NOP_OPCODE};

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_S3 = 2'd1;
  localparam logic [1:0] FWD_S4 = 2'd2;

  function automatic logic writes_reg(input opcode_t op);
    return !op[3] && !(op[1] && op[0]);
  endfunction

  // op[3] writers target the link register R7 instead of Rx
  function automatic reg_idx_t dest_reg(input instr_t w);
    return w[3] ? 3'd7 : w[7:5];
  endfunction

  function automatic logic reads_rx(input opcode_t op);
    return (op != 5'b10000) && !op[3];
  endfunction

  function automatic logic reads_ry(input opcode_t op);
    return op[4] || (op == 5'b00100) || (op == 5'b00101);
  endfunction

endpackage

// File: rtl/instr_pipe_tracker_if.sv
// Fetch-side / decoder-side bundle of the pipe tracker; master drives fetch inputs.
// Forwarding selects exist only when FORWARD_EN is defined.
interface instr_pipe_tracker_if;
  import cpu_pipe_pkg::*;

  instr_t           instr_in;
  logic             instr_valid;
  logic             br_taken;
  logic [4:1][4:0]  opcode;
  instr_t           instr_s2;
  instr_t           instr_s3;
  instr_t           instr_s4;
  logic [4:1]       valid;
  logic             fetch_enable;
  logic             stall;
`ifdef FORWARD_EN
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
`endif

  modport master (
    output instr_in, instr_valid, br_taken,
    input  opcode, instr_s2, instr_s3, instr_s4, valid, fetch_enable, stall
`ifdef FORWARD_EN
    , input fwd_a_sel, fwd_b_sel
`endif
  );

  modport slave (
    input  instr_in, instr_valid, br_taken,
    output opcode, instr_s2, instr_s3, instr_s4, valid, fetch_enable, stall
`ifdef FORWARD_EN
    , output fwd_a_sel, fwd_b_sel
`endif
  );

endinterface

// File: rtl/pipe_hazard_unit.sv
// Combinational RAW detector between stage 2 and stages 3/4.
// With FORWARD_EN only load-use stalls; other hazards become forwarding selects.
module pipe_hazard_unit
  import cpu_pipe_pkg::*;
(
  input  instr_t     i_s2,
  input  instr_t     i_s3,
  input  instr_t     i_s4,
  input  logic [4:2] i_valid,
  output logic       o_stall
`ifdef FORWARD_EN
  ,
  output logic [1:0] o_fwd_a_sel,
  output logic [1:0] o_fwd_b_sel
`endif
);

  logic     w_wr3, w_wr4;
  logic     w_rx_live, w_ry_live;
  reg_idx_t w_d3, w_d4;
  logic     w_a3, w_a4, w_b3, w_b4;
  logic     w_h3, w_h4;

  // bubbles carry valid=0, so they never qualify as writers or readers
  assign w_wr3     = i_valid[3] & writes_reg(i_s3[4:0]);
  assign w_wr4     = i_valid[4] & writes_reg(i_s4[4:0]);
  assign w_d3      = dest_reg(i_s3);
  assign w_d4      = dest_reg(i_s4);
  assign w_rx_live = i_valid[2] & reads_rx(i_s2[4:0]);
  assign w_ry_live = i_valid[2] & reads_ry(i_s2[4:0]);

  assign w_a3 = w_rx_live & w_wr3 & (i_s2[7:5]  == w_d3);
  assign w_a4 = w_rx_live & w_wr4 & (i_s2[7:5]  == w_d4);
  assign w_b3 = w_ry_live & w_wr3 & (i_s2[10:8] == w_d3);
  assign w_b4 = w_ry_live & w_wr4 & (i_s2[10:8] == w_d4);

  assign w_h3 = w_a3 | w_b3;
  assign w_h4 = w_a4 | w_b4;

`ifdef FORWARD_EN
  // a load's data is not ready in stage 3, so only that case must wait
  assign o_stall     = w_h3 & (i_s3[4:0] == LOAD_OPCODE);
  assign o_fwd_a_sel = w_a3 ? FWD_S3 : (w_a4 ? FWD_S4 : FWD_RF);
  assign o_fwd_b_sel = w_b3 ? FWD_S3 : (w_b4 ? FWD_S4 : FWD_RF);
`else
  assign o_stall = w_h3 | w_h4;
`endif

endmodule

// File: rtl/instr_pipe_tracker.sv
// Four-stage in-flight instruction tracker: stage registers plus flush/stall muxing.
// Build with FORWARD_EN to expose operand forwarding selects.
module instr_pipe_tracker
  import cpu_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  instr_pipe_tracker_if.slave  p
);

  instr_t     r_s1, r_s2, r_s3, r_s4;
  logic [4:1] r_valid;

  instr_t     w_s1_nx, w_s2_nx, w_s3_nx, w_s4_nx;
  logic [4:1] w_valid_nx;
  logic       w_hz_stall;
  logic       w_stall;

  pipe_hazard_unit u_hazard (
    .i_s2        (r_s2),
    .i_s3        (r_s3),
    .i_s4        (r_s4),
    .i_valid     (r_valid[4:2]),
    .o_stall     (w_hz_stall)
`ifdef FORWARD_EN
    ,
    .o_fwd_a_sel (p.fwd_a_sel),
    .o_fwd_b_sel (p.fwd_b_sel)
`endif
  );

  // a taken branch flushes the stalled instruction, so the stall is void that cycle
  assign w_stall = w_hz_stall & ~p.br_taken;

  // next stage contents: branch flush beats stall, stall beats advance
  always_comb begin
    w_s1_nx    = r_s1;
    w_s2_nx    = r_s2;
    w_s3_nx    = r_s3;
    w_s4_nx    = r_s3;
    w_valid_nx = r_valid;
    if (p.br_taken) begin
      w_s1_nx    = BUBBLE;
      w_s2_nx    = BUBBLE;
      w_s3_nx    = BUBBLE;
      w_valid_nx = {r_valid[3], 3'b000};
    end else if (w_hz_stall) begin
      w_s3_nx    = BUBBLE;
      w_valid_nx = {r_valid[3], 1'b0, r_valid[2:1]};
    end else begin
      w_s3_nx    = r_s2;
      w_s2_nx    = r_s1;
      w_s1_nx    = p.instr_valid ? p.instr_in : BUBBLE;
      w_valid_nx = {r_valid[3:1], p.instr_valid};
    end
  end

  // stage registers with synchronous active-low reset to an all-bubble pipe
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= BUBBLE;
      r_s2    <= BUBBLE;
      r_s3    <= BUBBLE;
      r_s4    <= BUBBLE;
      r_valid <= 4'b0000;
    end else begin
      r_s1    <= w_s1_nx;
      r_s2    <= w_s2_nx;
      r_s3    <= w_s3_nx;
      r_s4    <= w_s4_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign p.opcode[1]    = r_s1[4:0];
  assign p.opcode[2]    = r_s2[4:0];
  assign p.opcode[3]    = r_s3[4:0];
  assign p.opcode[4]    = r_s4[4:0];
  assign p.instr_s2     = r_s2;
  assign p.instr_s3     = r_s3;
  assign p.instr_s4     = r_s4;
  assign p.valid        = r_valid;
  assign p.stall        = w_stall;
  assign p.fetch_enable = ~w_stall;

endmodule

// File: tb/tb_instr_pipe_tracker.sv
// Directed self-checking bench for instr_pipe_tracker (default build; FORWARD_EN cases guarded).
module tb_instr_pipe_tracker;
  import cpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  instr_pipe_tracker_if pif ();

  instr_pipe_tracker dut (
    .clk   (clk),
    .reset (reset),
    .p     (pif)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {5'b00000, ry, rx, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    pif.instr_valid = 1'b0;
    pif.br_taken    = 1'b0;
    repeat (4) tick();
  endtask

  instr_t st [4];
  instr_t x_i, y_i, l_i, u_i, br_i, z_i;
  logic [19:0] all_nop;

  initial begin
    pif.instr_in    = '0;
    pif.instr_valid = 1'b0;
    pif.br_taken    = 1'b0;
    all_nop = {4{5'b00111}};
    st[0] = mk(5'b00000, 3'd1, 3'd0);
    st[1] = mk(5'b00001, 3'd2, 3'd0);
    st[2] = mk(5'b00010, 3'd3, 3'd0);
    st[3] = mk(5'b00000, 3'd4, 3'd0);
    x_i  = mk(5'b10001, 3'd1, 3'd2);
    y_i  = mk(5'b10001, 3'd3, 3'd1);
    l_i  = mk(5'b00100, 3'd1, 3'd2);
    u_i  = mk(5'b10001, 3'd1, 3'd3);
    br_i = mk(5'b01000, 3'd0, 3'd0);
    z_i  = mk(5'b00010, 3'd4, 3'd0);

    // 1. reset state
    tick();
    tick();
    chk("rst_opcode", 32'(pif.opcode), 32'(all_nop));
    chk("rst_valid",  32'(pif.valid), 32'h0);
    chk("rst_stall",  32'(pif.stall), 32'h0);
    chk("rst_fe",     32'(pif.fetch_enable), 32'h1);
    reset = 1'b1;

    // 2. hazard-free stream, 3-cycle s1->s4 latency
    pif.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif.instr_in = st[i];
      tick();
      chk("stream_s1_op", 32'(pif.opcode[1]), 32'(st[i][4:0]));
      chk("stream_stall", 32'(pif.stall), 32'h0);
    end
    chk("stream_s4_0", 32'(pif.instr_s4), 32'(st[0]));
    chk("stream_valid", 32'(pif.valid), 32'hF);
    pif.instr_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("stream_s4", 32'(pif.instr_s4), 32'(st[i]));
    end
    drain();

`ifndef FORWARD_EN
    // 3. RAW without forwarding: two stall cycles, two bubbles into s3
    pif.instr_valid = 1'b1;
    pif.instr_in = x_i;
    tick();
    pif.instr_in = y_i;
    tick();
    chk("raw_e1_stall", 32'(pif.stall), 32'h0);
    pif.instr_valid = 1'b0;
    tick();
    chk("raw_e2_stall", 32'(pif.stall), 32'h1);
    chk("raw_e2_fe",    32'(pif.fetch_enable), 32'h0);
    chk("raw_e2_s3",    32'(pif.instr_s3), 32'(x_i));
    pif.instr_valid = 1'b1;
    pif.instr_in = mk(5'b00000, 3'd6, 3'd0);
    tick();
    chk("raw_e3_stall", 32'(pif.stall), 32'h1);
    chk("raw_e3_fe",    32'(pif.fetch_enable), 32'h0);
    chk("raw_e3_s3op",  32'(pif.opcode[3]), 32'(NOP_OPCODE));
    chk("raw_e3_v3",    32'(pif.valid[3]), 32'h0);
    chk("raw_e3_s4",    32'(pif.instr_s4), 32'(x_i));
    tick();
    chk("raw_e4_stall", 32'(pif.stall), 32'h0);
    chk("raw_e4_fe",    32'(pif.fetch_enable), 32'h1);
    chk("raw_e4_s3op",  32'(pif.opcode[3]), 32'(NOP_OPCODE));
    chk("raw_e4_v1",    32'(pif.valid[1]), 32'h0);
    chk("raw_e4_s2",    32'(pif.instr_s2), 32'(y_i));
    pif.instr_valid = 1'b0;
    tick();
    chk("raw_e5_s3",    32'(pif.instr_s3), 32'(y_i));
    drain();
`else
    // 4. load-use stalls once then forwards from s4; ALU result forwards from s3
    pif.instr_valid = 1'b1;
    pif.instr_in = l_i;
    tick();
    pif.instr_in = u_i;
    tick();
    pif.instr_valid = 1'b0;
    tick();
    chk("ld_stall",     32'(pif.stall), 32'h1);
    tick();
    chk("ld_stall_end", 32'(pif.stall), 32'h0);
    chk("ld_fwd_a",     32'(pif.fwd_a_sel), 32'h2);
    drain();
    pif.instr_valid = 1'b1;
    pif.instr_in = x_i;
    tick();
    pif.instr_in = u_i;
    tick();
    pif.instr_valid = 1'b0;
    tick();
    chk("alu_stall",    32'(pif.stall), 32'h0);
    chk("alu_fwd_a",    32'(pif.fwd_a_sel), 32'h1);
    drain();
`endif

    // 5a. taken branch flushes s1..s3, branch moves to s4, fetched word dropped
    pif.instr_valid = 1'b1;
    pif.instr_in = br_i;
    tick();
    pif.instr_in = mk(5'b00000, 3'd5, 3'd0);
    tick();
    pif.instr_in = mk(5'b00000, 3'd6, 3'd0);
    tick();
    chk("br_pre_stall", 32'(pif.stall), 32'h0);
    chk("br_pre_s3",    32'(pif.instr_s3), 32'(br_i));
    pif.instr_in = mk(5'b00000, 3'd2, 3'd0);
    pif.br_taken = 1'b1;
    tick();
    pif.br_taken = 1'b0;
    pif.instr_valid = 1'b0;
    chk("br_valid",  32'(pif.valid), 32'h8);
    chk("br_s4",     32'(pif.instr_s4), 32'(br_i));
    chk("br_s1op",   32'(pif.opcode[1]), 32'(NOP_OPCODE));
    chk("br_s2op",   32'(pif.opcode[2]), 32'(NOP_OPCODE));
    chk("br_s3op",   32'(pif.opcode[3]), 32'(NOP_OPCODE));
    drain();

    // 5b. taken branch coinciding with a load-use stall
    pif.instr_valid = 1'b1;
    pif.instr_in = l_i;
    tick();
    pif.instr_in = u_i;
    tick();
    pif.instr_valid = 1'b0;
    tick();
    chk("brst_stall",  32'(pif.stall), 32'h1);
    pif.br_taken = 1'b1;
    tick();
    pif.br_taken = 1'b0;
    chk("brst_valid",  32'(pif.valid), 32'h8);
    chk("brst_s4",     32'(pif.instr_s4), 32'(l_i));
    chk("brst_s2op",   32'(pif.opcode[2]), 32'(NOP_OPCODE));
    chk("brst_stall2", 32'(pif.stall), 32'h0);
    drain();

    // 6. reset during a stall, then normal flow
    pif.instr_valid = 1'b1;
    pif.instr_in = l_i;
    tick();
    pif.instr_in = u_i;
    tick();
    pif.instr_valid = 1'b0;
    tick();
    chk("rs_stall",   32'(pif.stall), 32'h1);
    reset = 1'b0;
    tick();
    chk("rs_opcode",  32'(pif.opcode), 32'(all_nop));
    chk("rs_valid",   32'(pif.valid), 32'h0);
    chk("rs_stall0",  32'(pif.stall), 32'h0);
    chk("rs_fe",      32'(pif.fetch_enable), 32'h1);
    reset = 1'b1;
    pif.instr_valid = 1'b1;
    pif.instr_in = z_i;
    tick();
    chk("rs_z_s1",    32'(pif.opcode[1]), 32'(z_i[4:0]));
    pif.instr_valid = 1'b0;
    repeat (3) tick();
    chk("rs_z_s4",    32'(pif.instr_s4), 32'(z_i));
    chk("rs_z_valid", 32'(pif.valid), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
